// File: rtl/xoodoo_masked_pkg.sv
// Shared definitions for the masked Xoodoo permutation engine.
// Contents: state types, FSM encoding, round constants, index helpers
// (lane/plane/pair), rotation helper and a parameter legality check.
package xoodoo_masked_pkg;

  localparam int NLANES     = 12;
  localparam int SLICE_BITS = 384;

  typedef logic [31:0]      lane_t;
  typedef lane_t [11:0]     xstate_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  localparam logic [11:0] RC [12] = '{
    12'h058, 12'h038, 12'h3C0, 12'h0D0, 12'h120, 12'h014,
    12'h060, 12'h02C, 12'h380, 12'h0F0, 12'h1A0, 12'h012
  };

  function automatic logic [11:0] rc_at(input logic [3:0] idx);
    return (idx < 4'd12) ? RC[idx] : 12'h000;
  endfunction

  // Lane x of plane y, both taken modulo their extent so callers may
  // use offsets such as x+3 or y+2 directly.
  function automatic int lane(input int x, input int y);
    return 4 * (y % 3) + (x % 4);
  endfunction

  function automatic int plane_of(input int l);
    return l / 4;
  endfunction

  // Index of the unordered share pair {i,j}, ascending (0,1),(0,2),..,(1,2),..
  function automatic int pair_idx(input int i, input int j, input int ns);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * ns - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  function automatic lane_t rotl(input lane_t w, input int n);
    return (w << n) | (w >> (32 - n));
  endfunction

  function automatic bit legal_params(input int ns, input int rpc);
    return (ns >= 2) && (ns <= 4) &&
           ((rpc == 1) || (rpc == 2) || (rpc == 3) || (rpc == 6));
  endfunction

endpackage

// File: rtl/xoodoo_masked_perm_round.sv
// One combinational d-share Xoodoo round.
// Ports: st_i  - input state shares
//        rnd_i - one 384-bit fresh slice per share pair, ascending pair order
//        rc_i  - round constant, injected into share 0 only
//        st_o  - output state shares
// Linear steps run share-wise; chi uses DOM cross terms, each pair's slice
// masking a_i&b_j and a_j&b_i so it cancels on recombination.
module xoodoo_round_dom
  import xoodoo_masked_pkg::*;
#(
  parameter int NSHARES = 2
) (
  input  xstate_t [NSHARES-1:0]                          st_i,
  input  logic [SLICE_BITS*NSHARES*(NSHARES-1)/2-1:0]    rnd_i,
  input  logic [11:0]                                    rc_i,
  output xstate_t [NSHARES-1:0]                          st_o
);

  xstate_t [NSHARES-1:0] pre;
  xstate_t [NSHARES-1:0] post;

  function automatic xstate_t theta_rho_west(input xstate_t a);
    xstate_t t, r;
    lane_t   p, e;
    t = a;
    for (int x = 0; x < 4; x++) begin
      p = a[lane(x + 3, 0)] ^ a[lane(x + 3, 1)] ^ a[lane(x + 3, 2)];
      e = rotl(p, 5) ^ rotl(p, 14);
      for (int y = 0; y < 3; y++) t[lane(x, y)] = t[lane(x, y)] ^ e;
    end
    r = t;
    for (int x = 0; x < 4; x++) begin
      r[lane(x, 1)] = t[lane(x + 3, 1)];
      r[lane(x, 2)] = rotl(t[lane(x, 2)], 11);
    end
    return r;
  endfunction

  function automatic xstate_t rho_east(input xstate_t a);
    xstate_t r;
    r = a;
    for (int x = 0; x < 4; x++) begin
      r[lane(x, 1)] = rotl(a[lane(x, 1)], 1);
      r[lane(x, 2)] = rotl(a[lane(x + 2, 2)], 8);
    end
    return r;
  endfunction

  always_comb begin
    pre = '0;
    for (int s = 0; s < NSHARES; s++) pre[s] = theta_rho_west(st_i[s]);
    pre[0][0] = pre[0][0] ^ {20'd0, rc_i};
  end

  // ~a is realised by inverting share 0 of the a operand only.
  always_comb begin
    post = pre;
    for (int i = 0; i < NSHARES; i++)
      for (int j = 0; j < NSHARES; j++)
        for (int y = 0; y < 3; y++)
          for (int x = 0; x < 4; x++)
            post[i][lane(x, y)] = post[i][lane(x, y)]
              ^ ((pre[i][lane(x, y + 1)] ^ {32{i == 0}}) & pre[j][lane(x, y + 2)])
              ^ ((i == j) ? 32'h0
                 : rnd_i[SLICE_BITS * pair_idx(i, j, NSHARES) + 32 * lane(x, y) +: 32]);
  end

  always_comb begin
    st_o = '0;
    for (int s = 0; s < NSHARES; s++) st_o[s] = rho_east(post[s]);
  end

endmodule

// File: rtl/xoodoo_masked_perm.sv
// Masked Xoodoo permutation engine with a lane-wide state access port.
// Ports: clk_i/rst_i (sync, active high); init_i clears state; start_i/half_i
//        launch Xoodoo[12] or Xoodoo[6]; busy_o/done_o status; rdi_* fresh
//        randomness stream (stalls when absent); word_* lane write/read of all
//        shares; domain_* XORs into share 0 of lane 11.
//
// state  | meaning
// IDLE   | waiting; state writable
// RUN    | applying RPC rounds per cycle with valid randomness
// DONE   | one-cycle completion pulse; state writable
module xoodoo_masked_perm
  import xoodoo_masked_pkg::*;
#(
  parameter int  NSHARES = 2,
  parameter int  RPC     = 1,
  localparam int RND_W   = RPC * SLICE_BITS * NSHARES * (NSHARES - 1) / 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   init_i,
  input  logic                   start_i,
  input  logic                   half_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [RND_W-1:0]       rdi_data_i,
  input  logic                   rdi_valid_i,
  output logic                   rdi_ready_o,
  input  logic [32*NSHARES-1:0]  word_in_i,
  input  logic [3:0]             word_index_i,
  input  logic                   word_we_i,
  input  logic [31:0]            domain_i,
  input  logic                   domain_we_i,
  output logic [32*NSHARES-1:0]  word_out_o
);

  localparam int STEP_W = SLICE_BITS * NSHARES * (NSHARES - 1) / 2;

  if (!legal_params(NSHARES, RPC)) begin : g_bad_params
    $error("xoodoo_masked_perm: unsupported NSHARES/RPC combination");
  end

  fsm_e                  state_q, state_d;
  xstate_t [NSHARES-1:0] st_q, st_d;
  logic [3:0]            rnd_q, rnd_d;
  xstate_t [NSHARES-1:0] chain [RPC+1];

  assign chain[0] = st_q;

  for (genvar k = 0; k < RPC; k++) begin : g_round
    xoodoo_round_dom #(.NSHARES(NSHARES)) u_round (
      .st_i  (chain[k]),
      .rnd_i (rdi_data_i[k*STEP_W +: STEP_W]),
      .rc_i  (rc_at(rnd_q + 4'(k))),
      .st_o  (chain[k+1])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rdi_ready_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          rnd_d   = half_i ? 4'd6 : 4'd0;
        end
      end
      S_RUN: begin
        busy_o      = 1'b1;
        rdi_ready_o = 1'b1;
        if (rdi_valid_i) begin
          st_d  = chain[RPC];
          rnd_d = rnd_q + 4'(RPC);
          if (rnd_d == 4'd12) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Host access only outside RUN; init wins, then lane write, then domain XOR
    // on top so a same-cycle lane-11 write and domain inject combine.
    if (state_q != S_RUN) begin
      if (init_i) begin
        st_d = '0;
      end else begin
        if (word_we_i && (word_index_i < 4'd12))
          for (int s = 0; s < NSHARES; s++) st_d[s][word_index_i] = word_in_i[32*s +: 32];
        if (domain_we_i) st_d[0][11] = st_d[0][11] ^ domain_i;
      end
    end
  end

  always_comb begin
    word_out_o = '0;
    if (word_index_i < 4'd12)
      for (int s = 0; s < NSHARES; s++) word_out_o[32*s +: 32] = st_q[s][word_index_i];
  end

endmodule

// File: doc/xoodoo_masked_perm.md
Name: xoodoo_masked_perm

Overview:
Parametrised, d-share masked Xoodoo permutation engine with a word-level state access port.
It is the next generation of the 2-share controller used by CryptoCore_SCA:
- share count, rounds-per-cycle and round count (12 or 6) are generic;
- randomness is a true valid/ready stream, and the engine stalls when it is absent instead of substituting zeros.
It sits between the CryptoCore FSM (state load, domain injection, start, readout) and the external random-data-in (RDI) source.

Parameters:
NSHARES, 2, number of Boolean shares (legal 2..4).
RPC, 1, unrolled rounds per clock (legal 1, 2, 3, 6).
RND_W, RPC*384*NSHARES*(NSHARES-1)/2, derived localparam: fresh-randomness bits consumed per advancing cycle.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
init_i  in  1  clear all shares of the state to zero (IDLE only)
start_i  in  1  launch permutation (IDLE only)
half_i  in  1  sampled at start: 0 = Xoodoo[12], 1 = Xoodoo[6]
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse when the result is ready
rdi_data_i  in  RND_W  fresh randomness
rdi_valid_i  in  1  randomness valid
rdi_ready_o  out  1  randomness consumed this cycle
word_in_i  in  32*NSHARES  one 32-bit lane per share (share s at [32s+31:32s])
word_index_i  in  4  lane index 0..11
word_we_i  in  1  write lane
domain_i  in  32  domain/cd word
domain_we_i  in  1  XOR domain_i into share 0 of lane 11
word_out_o  out  32*NSHARES  lane word_index_i of all shares, combinational read

Behaviour:
- Clock and reset: one clock clk_i; rst_i is synchronous and active-high.
- Reset values: FSM to IDLE, state all-zero, round counter 0, busy_o=0, done_o=0, rdi_ready_o=0.
- Reset asserted mid-RUN aborts immediately. The state is zeroed and no done_o is produced.
- FSM states:
  - IDLE: start_i -> RUN. Latch half_i; round index r = half_i ? 6 : 0.
  - RUN: rdi_ready_o=1.
    - When rdi_valid_i=1, apply RPC masked rounds using constants RC[r..r+RPC-1], then r += RPC.
    - When rdi_valid_i=0, hold the state and r (stall, no randomness substitution).
    - When r reaches 12 on an advancing cycle -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- Latency: with continuous valid randomness, done_o rises (12-r0)/RPC + 1 cycles after start_i. Each stall cycle adds one cycle.
- Round constants RC[0..11]: 058 038 3C0 0D0 120 014 060 02C 380 0F0 1A0 012 (hex). RC is XORed into share 0 only.
- Linear layers (theta, rho-west, rho-east) are applied share-wise.
- Chi is computed DOM-style:
  - each cross-share term a_i AND b_j (i≠j) is refreshed with one 384-bit slice of rdi_data_i;
  - slices are assigned in ascending (i<j) pair order, round-major.
- State write port:
  - word_we_i and domain_we_i act only in IDLE and DONE. Both are ignored in RUN; the state stays intact.
  - word_we_i overwrites all shares of the lane.
  - If word_we_i and domain_we_i both target lane 11 in the same cycle, the stored share 0 is word_in_i share 0 XOR domain_i.
  - init_i has priority over both writes in the same cycle.
- word_index_i values 12..15:
  - writes are ignored;
  - word_out_o returns zero.
- start_i in RUN or DONE is ignored. start_i with init_i in the same cycle: clear first, then run on the zero state.
- Unmasked value = XOR of all shares. Output share values are implementation-defined; only the recombined value is checked.

Decomposition:
- Package xoodoo_masked_pkg:
  - RC constant array;
  - lane/plane index helpers;
  - legal-parameter assertion function (RPC in {1,2,3,6}, 2≤NSHARES≤4).
- Sub-module xoodoo_round_dom:
  - one combinational d-share round, taking the state shares, a 384*NSHARES*(NSHARES-1)/2 randomness slice and a 12-bit RC;
  - instantiated RPC times in a generate chain.

Test Plan:
- Each scenario compares the recombined output against the golden reference model.
- Zero state (one share fresh random, other shares XOR-corrected to zero), NSHARES=2, RPC=1, half_i=0, rdi_valid held 1 -> done_o at cycle 13 after start; recombined output equals golden Xoodoo[12](0).
- Same input with NSHARES=3, RPC=3 and random rdi_data -> done_o at cycle 5; recombined result identical to the NSHARES=2 run.
- half_i=1, RPC=2, random state -> 3 advancing cycles; recombined output equals golden Xoodoo[6].
- Toggle rdi_valid_i 1,0,0,1... during RUN -> r advances only on valid cycles; done_o delayed by the exact stall count; result unchanged versus the no-stall run.
- word_we_i / domain_we_i pulsed during RUN -> no effect on the result. Same-cycle word_we_i and domain_we_i on lane 11 in IDLE (lane=0x00000001, domain=0x00000003) -> readback share0^share1 = 0x00000002.
- rst_i asserted at round 5 -> next cycle busy_o=0, word_out_o=0 for all lanes, no done_o; a subsequent start_i completes normally.
